// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and the NOP word
// delivered in place of an instruction on a fetch fault.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch stage between the PC register and decode.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT-state response timeout that faults with a NOP.
//
// state | meaning
// IDLE  | first cycle after reset; latches pc_in on exit
// REQ   | request req_pc (or fault on misaligned pc); no request while a dropped response is pending
// WAIT  | request granted, waiting for rvalid
// HOLD  | instr presented to decode until accepted or flushed
module instr_fetch_unit #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] NOP_INSTR      = XLEN'(fetch_pkg::NOP_INSTR),
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            fetch_stall,
  output logic            fetch_fault
);

  import fetch_pkg::fetch_state_e;
  import fetch_pkg::IDLE;
  import fetch_pkg::REQ;
  import fetch_pkg::WAIT;
  import fetch_pkg::HOLD;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            valid_q;
  logic            fault_q;
  logic            drop_q;

  logic aligned;
  logic handshake;
  logic timeout;
  logic load_pc;
  logic capture;
  logic fault_load;
  logic retire;

  assign aligned     = (req_pc_q[1:0] == 2'b00);
  assign imem_req    = !rst && (state_q == REQ) && aligned && !drop_q;
  // flush wins over a same-cycle decode handshake, so the PC never advances on a redirect
  assign handshake   = !rst && (state_q == HOLD) && valid_q && instr_ready && !flush;
  assign fetch_stall = !handshake;

  assign imem_addr   = req_pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_fault = fault_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMR_W-1:0] tmr_q;

  // preloaded outside WAIT, so it starts from TIMEOUT_CYCLES-1 on every WAIT entry
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (state_q != WAIT) begin
      tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - TMR_W'(1);
    end
  end

  assign timeout = (state_q == WAIT) && (tmr_q == '0) && !imem_rvalid;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    load_pc    = 1'b0;
    capture    = 1'b0;
    fault_load = 1'b0;
    retire     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        load_pc = 1'b1;
      end
      REQ: begin
        if (flush) begin
          load_pc = 1'b1;
        end else if (!aligned) begin
          state_d    = HOLD;
          fault_load = 1'b1;
        end else if (imem_req && imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = REQ;
          load_pc = 1'b1;
        end else if (imem_rvalid) begin
          state_d = HOLD;
          capture = 1'b1;
        end else if (timeout) begin
          state_d    = HOLD;
          fault_load = 1'b1;
        end
      end
      HOLD: begin
        if (flush || handshake) begin
          state_d = REQ;
          load_pc = 1'b1;
          retire  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // one outstanding response at most; a flushed or timed-out one is swallowed here
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (drop_q && imem_rvalid) begin
      drop_q <= 1'b0;
    end else if ((state_q == REQ) && flush && imem_req && imem_gnt) begin
      drop_q <= 1'b1;
    end else if ((state_q == WAIT) && flush && !imem_rvalid) begin
      drop_q <= 1'b1;
    end else if (timeout) begin
      drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_q   <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (load_pc) begin
        req_pc_q <= pc_in;
      end
      if (capture) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= req_pc_q;
        valid_q    <= 1'b1;
        fault_q    <= 1'b0;
      end else if (fault_load) begin
        instr_q    <= NOP_INSTR;
        instr_pc_q <= req_pc_q;
        valid_q    <= 1'b1;
        fault_q    <= 1'b1;
      end else if (retire) begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then randomized
// traffic against a transaction-level reference model and a behavioural instruction memory.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          TC  = 4;
`ifdef FETCH_TIMEOUT_EN
  localparam int MAXD = 7;
`else
  localparam int MAXD = 4;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_stall;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;
  bit e2e_en   = 0;

  // reference model: what decode should see, expressed as fetch progress rather than FSM states
  bit          m_boot;
  bit          m_asked;
  bit          m_drop;
  bit          m_out_valid;
  bit          m_out_fault;
  logic [31:0] m_addr;
  logic [31:0] m_out_instr;
  logic [31:0] m_out_pc;
  int          m_elapsed;

  // behavioural memory
  bit          mem_pending;
  logic [31:0] mem_addr;
  int          mem_delay;
  bit          granted_prev;
  logic [31:0] g_addr;

  instr_fetch_unit #(.XLEN(32), .TIMEOUT_CYCLES(TC)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_stall (fetch_stall),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5EED_0000) + 32'h0000_1001;
  endfunction

  function automatic bit exp_req_f();
    return (rst === 1'b0) && !m_boot && !m_asked && !m_out_valid && (m_addr[1:0] == 2'b00) && !m_drop;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic deliver(input logic [31:0] word, input bit fault);
    m_out_valid = 1;
    m_out_instr = word;
    m_out_pc    = m_addr;
    m_out_fault = fault;
  endtask

  task automatic model_step();
    bit pre_req;
    pre_req = exp_req_f();
    if (rst === 1'b1) begin
      m_boot      = 1;
      m_asked     = 0;
      m_drop      = 0;
      m_out_valid = 0;
      m_out_fault = 0;
      m_addr      = '0;
      m_out_instr = '0;
      m_out_pc    = '0;
      m_elapsed   = 0;
    end else if (m_boot) begin
      m_boot = 0;
      m_addr = pc_in;
    end else begin
      if (m_drop && imem_rvalid) m_drop = 0;
      if (m_out_valid) begin
        if (flush || instr_ready) begin
          m_out_valid = 0;
          m_out_fault = 0;
          m_addr      = pc_in;
        end
      end else if (m_asked) begin
        if (flush) begin
          m_asked = 0;
          m_drop  = !imem_rvalid;
          m_addr  = pc_in;
        end else if (imem_rvalid) begin
          m_asked = 0;
          deliver(imem_rdata, 0);
        end else begin
          m_elapsed++;
`ifdef FETCH_TIMEOUT_EN
          if (m_elapsed >= TC) begin
            m_asked = 0;
            deliver(NOP, 1);
            m_drop = 1;
          end
`endif
        end
      end else begin
        if (flush) begin
          if (pre_req && imem_gnt) m_drop = 1;
          m_addr = pc_in;
        end else if (m_addr[1:0] != 2'b00) begin
          deliver(NOP, 1);
        end else if (pre_req && imem_gnt) begin
          m_asked   = 1;
          m_elapsed = 0;
        end
      end
    end
  endtask

  task automatic compare();
    bit er;
    bit es;
    er = exp_req_f();
    es = !((rst === 1'b0) && m_out_valid && instr_ready && !flush);
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, es});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_out_valid});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_out_fault});
    if (er) chk("imem_addr", imem_addr, m_addr);
    if (m_out_valid) begin
      chk("instr", instr, m_out_instr);
      chk("instr_pc", instr_pc, m_out_pc);
      if (e2e_en && !m_out_fault) chk("instr_vs_mem", instr, mem_word(m_out_pc));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) compare();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    instr_ready = 0; pc_in = '0;
    mem_pending = 0; mem_addr = '0; mem_delay = 0; granted_prev = 0; g_addr = '0;
    tick();
    tick();
    chk_en = 1;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd1);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

    // basic fetch, same-cycle grant, response next cycle
    rst = 0; instr_ready = 1; pc_in = 32'h0;
    #1 chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick(); imem_gnt = 1;
    #1 chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093;
    #1 chk("t1_wait_valid", {31'd0, instr_valid}, 32'd0);
    tick(); imem_rvalid = 0; imem_rdata = '0; pc_in = 32'h4;
    #1 chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_pc", instr_pc, 32'h0);
    chk("t1_stall_low", {31'd0, fetch_stall}, 32'd0);

    // delayed grant, decode back-pressure
    tick(); instr_ready = 0;
    #1 chk("t1_stall_back", {31'd0, fetch_stall}, 32'd1);
    pc_in = 32'h102;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 chk("t2_req_hold", {31'd0, imem_req}, 32'd1);
      chk("t2_addr_hold", imem_addr, 32'h4);
    end
    imem_gnt = 1;
    tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    tick(); imem_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_instr_hold", instr, 32'h1234_5678);
      chk("t2_pc_hold", instr_pc, 32'h4);
      chk("t2_stall_hold", {31'd0, fetch_stall}, 32'd1);
      if (i < 3) tick();
    end
    instr_ready = 1;
    #1 chk("t2_stall_low", {31'd0, fetch_stall}, 32'd0);

    // misaligned pc faults without a request
    tick(); pc_in = 32'h20;
    #1 chk("t3_no_req", {31'd0, imem_req}, 32'd0);
    tick();
    #1 chk("t3_instr", instr, NOP);
    chk("t3_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t3_pc", instr_pc, 32'h102);

    // flush during WAIT; the stale response must be discarded
    tick(); imem_gnt = 1;
    #1 chk("t4_addr", imem_addr, 32'h20);
    tick(); imem_gnt = 0; flush = 1; pc_in = 32'h40;
    tick(); flush = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    #1 chk("t4_req_blocked", {31'd0, imem_req}, 32'd0);
    tick(); imem_rvalid = 0;
    #1 chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr_new", imem_addr, 32'h40);
    imem_gnt = 1;
    tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00a0_0113;
    tick(); imem_rvalid = 0; pc_in = 32'h80;
    #1 chk("t4_instr", instr, 32'h00a0_0113);
    chk("t4_pc", instr_pc, 32'h40);

    // flush in HOLD beats a same-cycle decode handshake
    tick(); imem_gnt = 1;
    tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1111_1111;
    tick(); imem_rvalid = 0; flush = 1;
    #1 chk("t5_stall", {31'd0, fetch_stall}, 32'd1);
    tick(); flush = 0;
    #1 chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_refetch", imem_addr, 32'h80);

`ifdef FETCH_TIMEOUT_EN
    instr_ready = 0; imem_gnt = 1;
    tick(); imem_gnt = 0;
    tick(); tick(); tick();
    #1 chk("t6_still_wait", {31'd0, instr_valid}, 32'd0);
    tick(); imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
    #1 chk("t6_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t6_instr", instr, NOP);
    chk("t6_pc", instr_pc, 32'h80);
    tick(); imem_rvalid = 0;
    #1 chk("t6_late_ignored", instr, NOP);
    instr_ready = 1; pc_in = 32'hC0;
    tick();
    #1 chk("t6_next_addr", imem_addr, 32'hC0);
    chk("t6_next_req", {31'd0, imem_req}, 32'd1);
`endif

    // randomized traffic
    imem_gnt = 0; imem_rvalid = 0; flush = 0;
    e2e_en = 1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (granted_prev) begin
        mem_pending = 1;
        mem_addr    = g_addr;
        mem_delay   = $urandom_range(1, MAXD);
      end
      imem_rvalid = 0;
      imem_rdata  = $urandom;
      if (mem_pending) begin
        mem_delay--;
        if (mem_delay == 0) begin
          imem_rvalid = 1;
          imem_rdata  = mem_word(mem_addr);
          mem_pending = 0;
        end
      end
      rst = (c >= 2000 && c < 2002);
      if (rst) begin
        imem_rvalid = 0;
        mem_pending = 0;
      end
      flush       = ($urandom_range(0, 99) < 7);
      instr_ready = ($urandom_range(0, 99) < 60);
      pc_in       = ($urandom_range(0, 99) < 10) ? 32'($urandom) : (32'($urandom) & ~32'h3);
      imem_gnt    = exp_req_f() && !mem_pending && ($urandom_range(0, 99) < 50);
      g_addr      = m_addr;
      granted_prev = imem_gnt;
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
